// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  // PC mux select produced by br_calc in execute.
  typedef enum logic {
    pcmux_pc  = 1'b0,
    pcmux_jmp = 1'b1
  } pcmux_selop;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    fs_req   = 2'd0,
    fs_wait  = 2'd1,
    fs_drop  = 2'd2,
    fs_fault = 2'd3
  } fetch_state;

  // addi x0,x0,0
  localparam logic [31:0] rvga_nop = 32'h0000_0013;

  // Sequential successor of a fetch address; 0xFFFFFFFC wraps to 0.
  function automatic logic [31:0] pc_seq_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Redirect targets arrive halfword aligned; bit 0 is never part of a PC.
  function automatic logic [31:0] clear_lsb(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFE;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus: req/gnt handshake plus rvalid response.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_pc_reg.sv
// Architectural PC register with sequential increment and redirect mux.
module fetch_pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        advance,
  output logic [31:0] pc
);

  logic [31:0] pc_r;

  // Redirect wins over the sequential advance taken on a granted fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (redirect) begin
      pc_r <= redirect_pc;
    end else if (advance) begin
      pc_r <= pc_seq_next(pc_r);
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC ownership, one-outstanding imem fetch sequencer,
// single-entry output register towards decode, wrong-path flush on redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = rvga_nop
) (
  input  logic                clk,
  input  logic                rst,
  input  pcmux_selop          pcmux_sel,
  input  logic [31:0]         jmp_tgt,
  input  logic                stall,
  fetch_stage_if.master       imem,
  output logic                if_valid,
  output logic [31:0]         if_pc,
  output logic [31:0]         if_instr,
  output logic                if_fault
);

  fetch_state  state_r;
  logic [31:0] req_pc_r;
  logic        fault_pend_r;
  logic        if_valid_r;
  logic [31:0] if_pc_r;
  logic [31:0] if_instr_r;
  logic        if_fault_r;

  logic        redirect_s;
  logic [31:0] redirect_pc_s;
  logic        buf_free_s;
  logic        resp_owed_s;
  logic        retire_s;
  logic        req_s;
  logic        grant_s;
  logic [31:0] pc_s;

  assign redirect_s    = (pcmux_sel == pcmux_jmp);
  assign redirect_pc_s = clear_lsb(jmp_tgt);
  assign buf_free_s    = ~if_valid_r | ~stall;
  assign retire_s      = if_valid_r & ~stall;
  // A response is still owed if a request is in flight and it does not land this cycle.
  assign resp_owed_s   = ((state_r == fs_wait) || (state_r == fs_drop)) & ~imem.imem_rvalid;

  // Request only when the output entry will be free; rst gating keeps req low during reset.
  always_comb begin
    req_s = 1'b0;
    case (state_r)
      fs_req:   req_s = buf_free_s & ~redirect_s & ~rst;
      fs_wait:  req_s = 1'b0;
      fs_drop:  req_s = 1'b0;
      fs_fault: req_s = 1'b0;
      default:  req_s = 1'b0;
    endcase
  end

  assign grant_s        = req_s & imem.imem_gnt;
  assign imem.imem_req  = req_s;
  assign imem.imem_addr = pc_s;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect_s),
    .redirect_pc (redirect_pc_s),
    .advance     (grant_s),
    .pc          (pc_s)
  );

  // Fetch FSM and decode output register; redirect overrides every other event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= fs_req;
      req_pc_r     <= RESET_PC;
      fault_pend_r <= 1'b0;
      if_valid_r   <= 1'b0;
      if_pc_r      <= 32'h0000_0000;
      if_instr_r   <= NOP_INSTR;
      if_fault_r   <= 1'b0;
    end else if (redirect_s) begin
      if_instr_r <= NOP_INSTR;
      if (jmp_tgt[1] && !resp_owed_s) begin
        // Misaligned target with nothing in flight: report the fault now.
        state_r      <= fs_fault;
        fault_pend_r <= 1'b0;
        if_valid_r   <= 1'b1;
        if_fault_r   <= 1'b1;
        if_pc_r      <= redirect_pc_s;
      end else begin
        // Kill the entry; drain an owed response first (fault deferred if pending).
        state_r      <= resp_owed_s ? fs_drop : fs_req;
        fault_pend_r <= jmp_tgt[1];
        if_valid_r   <= 1'b0;
        if_fault_r   <= 1'b0;
      end
    end else begin
      case (state_r)
        fs_req: begin
          if (grant_s) begin
            req_pc_r <= pc_s;
            state_r  <= fs_wait;
          end
          if (retire_s) begin
            if_valid_r <= 1'b0;
            if_instr_r <= NOP_INSTR;
          end
        end
        fs_wait: begin
          if (imem.imem_rvalid) begin
            if_valid_r <= 1'b1;
            if_instr_r <= imem.imem_rdata;
            if_pc_r    <= req_pc_r;
            if_fault_r <= 1'b0;
            state_r    <= fs_req;
          end
        end
        fs_drop: begin
          if (imem.imem_rvalid) begin
            if (fault_pend_r) begin
              // PC already holds the misaligned target captured at redirect.
              state_r    <= fs_fault;
              if_valid_r <= 1'b1;
              if_fault_r <= 1'b1;
              if_pc_r    <= pc_s;
              if_instr_r <= NOP_INSTR;
            end else begin
              state_r <= fs_req;
            end
            fault_pend_r <= 1'b0;
          end
        end
        fs_fault: begin
          state_r <= fs_fault;
        end
        default: begin
          state_r      <= fs_req;
          fault_pend_r <= 1'b0;
          if_valid_r   <= 1'b0;
          if_fault_r   <= 1'b0;
          if_instr_r   <= NOP_INSTR;
        end
      endcase
    end
  end

  assign if_valid = if_valid_r;
  assign if_pc    = if_pc_r;
  assign if_instr = if_instr_r;
  assign if_fault = if_fault_r;

endmodule
